// File: rtl/cla_add_sequencer.sv
// Multi-cycle wide adder/subtractor. One operand pair is accepted through a
// valid/ready handshake and summed SLICE bits per cycle using 4-bit
// lookahead-carry groups; the slice carry-out is registered between cycles.
module cla_add_sequencer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned NGROUP = SLICE / 4;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef logic [IDXW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  idx_t             idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] a_s, b_s, s_slice;
  logic             slice_co;
  logic             msb_cin;

  // Lookahead-carry slice: per-group G/P with ripple between groups.
  always_comb begin
    logic [3:0] g, p, ci;
    logic       c, gg, pp;
    a_s     = a_q[idx_q*SLICE +: SLICE];
    b_s     = b_q[idx_q*SLICE +: SLICE];
    s_slice = '0;
    msb_cin = 1'b0;
    g       = '0;
    p       = '0;
    ci      = '0;
    gg      = 1'b0;
    pp      = 1'b0;
    c       = carry_q;
    for (int unsigned grp = 0; grp < NGROUP; grp++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        g[j] = a_s[grp*4 + j] & b_s[grp*4 + j];
        p[j] = a_s[grp*4 + j] ^ b_s[grp*4 + j];
      end
      ci[0] = c;
      for (int unsigned j = 0; j < 3; j++) begin
        ci[j+1] = g[j] | (p[j] & ci[j]);
      end
      for (int unsigned j = 0; j < 4; j++) begin
        s_slice[grp*4 + j] = p[j] ^ ci[j];
      end
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pp = &p;
      c  = gg | (pp & c);
      // Left holding the carry into the slice MSB after the final group.
      msb_cin = ci[3];
    end
    slice_co = c;
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b ^ {WIDTH{op_sub}};
          carry_d = op_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = s_slice;
        carry_d = slice_co;
        idx_d   = idx_q + idx_t'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_co;
          ovf_d   = msb_cin ^ slice_co;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Directed bench for cla_add_sequencer (WIDTH=64, SLICE=16).
module tb_cla_add_sequencer;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         busy;

  int n_cmp;
  int n_err;

  cla_add_sequencer #(.WIDTH(64), .SLICE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_sub   (op_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, check latency and result, then complete the handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] es, input logic ec, input logic eo);
    int cyc;
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_clr"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready_set"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, bb, es;
    logic [W:0]   full;
    logic         rs, eo, seen, done, hs;
    int           cyc;

    n_cmp = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // Full carry ripple, borrow, signed overflow
    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
    run_op("borrow", 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Backpressure: hold DONE while new operands are offered
    op_a = 64'd5; op_b = 64'd3; op_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_valid0", 64'(out_valid), 64'd1);
    chk("bp_sum0", sum, 64'd8);
    for (int i = 0; i < 5; i++) begin
      op_a = 64'hAAAA_0000_0000_1111 + 64'(i); op_b = 64'h1; op_sub = 1'(i);
      in_valid = (i % 2 == 0);
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_sum", sum, 64'd8);
      chk("bp_cout", 64'(cout), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_release_busy", 64'(busy), 64'd0);
    chk("bp_sum_kept", sum, 64'd8);

    // Reset in RUN at slice index 2
    op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'hFFFF_FFFF_FFFF_FFFF; op_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_sum", sum, 64'd0);
    repeat (6) tick();
    chk("mid_rst_no_result", 64'(out_valid), 64'd0);
    run_op("post_rst", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
           64'h2222_2222_2222_2211, 1'b0, 1'b0);

    // Back-to-back random operations with random out_ready stalls
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = rs ? 64'd0 : 64'd1;
      bb   = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + 65'(rs);
      es   = full[W-1:0];
      eo   = (ra[W-1] == bb[W-1]) && (es[W-1] != ra[W-1]);
      op_a = ra; op_b = rb; op_sub = rs;
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      tick();
      op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; op_sub = ~rs;
      out_ready = 1'($urandom_range(0, 1));
      cyc = 0; seen = 1'b0; done = 1'b0;
      while (!done && cyc < 64) begin
        hs = out_valid && out_ready;
        tick();
        cyc++;
        if (hs) begin
          done = 1'b1;
          chk("b2b_out_valid_clr", 64'(out_valid), 64'd0);
        end else begin
          if (out_valid && !seen) begin
            seen = 1'b1;
            chk("b2b_latency", 64'(cyc), 64'd4);
            chk("b2b_sum", sum, es);
            chk("b2b_cout", 64'(cout), 64'(full[W]));
            chk("b2b_ovf", 64'(overflow), 64'(eo));
          end
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      chk("b2b_handshake_timeout", 64'(done), 64'd1);
      if (!done) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
